pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial pattern transmitter: on request, shifts a fixed PAT_W-bit pattern (default 1001) out MSB-first, one bit per clock, for a programmed number of frames. It is the transmit side of the team's serial sequence detectors, used to drive detector inputs in system and loopback tests. It is a Moore FSM, and all outputs come from registers.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PAT, 4'b1001, pattern transmitted MSB first (PAT_W bits)
- CNT_W, 8, width of frame-repeat count

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset; outputs go to reset values immediately on assertion
- start  in  1  request pulse/level, sampled only in IDLE
- repeat_n  in  CNT_W  number of frames to send, captured with start
- abort  in  1  synchronous cancel, effective in any non-IDLE state
- dout  out  1  serial data bit
- dvalid  out  1  dout carries a pattern bit this cycle
- busy  out  1  block not in IDLE
- done  out  1  one-cycle pulse after final bit of final frame

## Operation
- Reset values: dout=0, dvalid=0, busy=0, done=0, state=IDLE, shift register=0, bit/frame counters=0.
- States: IDLE, SEND, GAP (only with GAP_EN), DONE.
- IDLE → SEND: start=1 and repeat_n≠0. On this transition, frames_left is loaded with repeat_n and the shift register with PAT.
- IDLE, start=1 and repeat_n=0: request ignored; stays IDLE; busy, dvalid and done stay 0.
- SEND:
  - Each cycle, dout=shreg[PAT_W-1] and dvalid=1; shift left and increment bit_cnt (0..PAT_W-1).
  - When bit_cnt=PAT_W-1: decrement frames_left and reset bit_cnt.
  - If frames_left was 1, go to DONE.
  - Otherwise, reload PAT and continue in SEND (back-to-back) or go to GAP (GAP_EN).
- GAP: one cycle with dvalid=0 and dout=0, then reload PAT and go to SEND.
- DONE: done=1, dvalid=0, dout=0 for exactly one cycle, then IDLE.
- start is ignored whenever state≠IDLE, including the DONE cycle.
- abort=1 in SEND, GAP or DONE: next state is IDLE, with dvalid=0, dout=0, done=0. No done pulse is produced, and any partial frame is truncated.
- abort in IDLE has no effect. If abort and start are both high in IDLE, start wins (abort is not applicable).
- The frame counter is CNT_W bits; repeat_n=2^CNT_W-1 is valid. There is no wrap, since the counter only decrements toward 1.
- Asserting rst mid-frame returns all outputs to reset values asynchronously. Deassertion is released on clk.

## Timing
- Edge k samples start (IDLE). First bit is on dout with dvalid=1 during cycle k+1.
- Without GAP_EN, a frame count of N produces dvalid high for N·PAT_W consecutive cycles, k+1..k+N·PAT_W. done is high in cycle k+N·PAT_W+1. busy is high from k+1 through the done cycle.
- With GAP_EN, add one idle cycle between frames. Total length is N·PAT_W+(N-1) cycles before DONE.
- The earliest next accepted start is in the first IDLE cycle after DONE. Restart spacing is therefore one full IDLE cycle after done.
- Abort sampled at edge j: outputs are idle (dvalid=0, busy=0) from cycle j+1.

## Configuration
- PATTERN_TX_GAP_EN defined: GAP state is compiled in, inserting exactly one dvalid=0, dout=0 cycle between consecutive frames. abort in GAP behaves as in SEND.
- Not defined: no GAP state, and frames are back-to-back. With the default PAT, the stream is 1001 1001…, whose shared 1 permits overlapping detection.

## Test plan
- Reset: hold rst=0 with start=1, then release. Required: all outputs 0, and no transmission until a start is sampled after release.
- Single frame: repeat_n=1, start at edge k. Required: dout=1,0,0,1 with dvalid=1 in cycles k+1..k+4, done=1 in k+5, busy=0 in k+6.
- Three frames, no GAP_EN: repeat_n=3. Required: 12 contiguous valid bits 100110011001, then a single done pulse. With GAP_EN: 1001,gap,1001,gap,1001 (14 cycles), then done.
- Ignored requests: start with repeat_n=0 leaves busy=0. start pulses during SEND and during DONE cause no restart and no change to the bit sequence.
- Abort: repeat_n=2, abort after the second bit. Required: dvalid=0 and busy=0 in the next cycle, done never asserted, and a fresh start then sends a complete 1001.
- Async reset mid-frame: drop rst during the third bit. Required: dout, dvalid and busy go to 0 before the next clk edge, and after release the block is IDLE.

Source files
------------

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx
// Purpose  : Serial transmitter that shifts a fixed PAT_W-bit pattern out
//            MSB-first for a programmed number of frames. Optional inter-frame
//            gap cycle is compiled in with `define PATTERN_TX_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_tx #(
  parameter int               PAT_W = 4,
  parameter logic [PAT_W-1:0] PAT   = 4'b1001,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  localparam int              c_BW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [c_BW-1:0] c_LAST = c_BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic [PAT_W-1:0]   r_shreg,       w_shreg_nxt;
  logic [c_BW-1:0]    r_bit_cnt,     w_bit_nxt;
  logic [CNT_W-1:0]   r_frames_left, w_frames_nxt;
  logic               r_dout, r_dvalid, r_busy, r_done;
  logic               w_dvalid_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bit_nxt    = r_bit_cnt;
    w_frames_nxt = r_frames_left;
    case (r_state)
      IDLE: begin
        if (start && (repeat_n != '0)) begin
          w_state_nxt  = SEND;
          w_shreg_nxt  = PAT;
          w_frames_nxt = repeat_n;
          w_bit_nxt    = '0;
        end
      end
      SEND: begin
        w_shreg_nxt = {r_shreg[PAT_W-2:0], 1'b0};
        if (r_bit_cnt == c_LAST) begin
          w_bit_nxt    = '0;
          w_frames_nxt = r_frames_left - CNT_W'(1);
          if (r_frames_left == CNT_W'(1)) begin
            w_state_nxt = DONE;
          end else begin
            w_shreg_nxt = PAT;
`ifdef PATTERN_TX_GAP_EN
            w_state_nxt = GAP;
`endif
          end
        end else begin
          w_bit_nxt = r_bit_cnt + c_BW'(1);
        end
      end
`ifdef PATTERN_TX_GAP_EN
      GAP:     w_state_nxt = SEND;
`endif
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Cancel wins over everything except an IDLE-state request
    if (abort && (r_state != IDLE)) begin
      w_state_nxt  = IDLE;
      w_shreg_nxt  = '0;
      w_bit_nxt    = '0;
      w_frames_nxt = '0;
    end
  end

  // Outputs are decoded from next-state so they come straight out of flops
  assign w_dvalid_nxt = (w_state_nxt == SEND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_frames_left <= '0;
      r_dout        <= 1'b0;
      r_dvalid      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_bit_cnt     <= w_bit_nxt;
      r_frames_left <= w_frames_nxt;
      r_dout        <= w_dvalid_nxt & w_shreg_nxt[PAT_W-1];
      r_dvalid      <= w_dvalid_nxt;
      r_busy        <= (w_state_nxt != IDLE);
      r_done        <= (w_state_nxt == DONE);
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_tx
// Purpose  : Self-checking bench for pattern_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_tx;

  localparam int         PAT_W = 4;
  localparam int         CNT_W = 8;
  localparam logic [3:0] PAT   = 4'b1001;
`ifdef PATTERN_TX_GAP_EN
  localparam bit         GAP_ON = 1'b1;
`else
  localparam bit         GAP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic             dout, dvalid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // expected per-cycle observation {dvalid, dout, busy, done}
  logic [3:0] exp_q[$];

  pattern_tx #(.PAT_W(PAT_W), .PAT(PAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_n(repeat_n), .abort(abort),
    .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Cycle-by-cycle stream for n frames; abort_at>=0 idles from that cycle on
  function automatic void build_model(input int n, input int abort_at);
    exp_q.delete();
    for (int f = 0; f < n; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({1'b1, PAT[b], 1'b1, 1'b0});
      if (GAP_ON && (f < n - 1)) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    if (abort_at >= 0) while (exp_q.size() > abort_at) void'(exp_q.pop_back());
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
  endfunction

  function automatic int stream_len(input int n);
    return n * PAT_W + (GAP_ON ? n - 1 : 0) + 1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    start = 1'b1; repeat_n = 8'd3;
    #1;
    n_checks++;
    if ({dvalid, dout, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async: got %b exp 0000", {dvalid, dout, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({dvalid, dout, busy, done} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_hold cyc%0d: got %b exp 0000", i, {dvalid, dout, busy, done});
      end
    end
    start = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({dvalid, dout, busy, done} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_release cyc%0d: got %b exp 0000", i, {dvalid, dout, busy, done});
      end
    end
  endtask

  task automatic test_frames(input int n, input string name);
    repeat_n = CNT_W'(n); start = 1'b1;
    step();
    start = 1'b0;
    build_model(n, -1);
    foreach (exp_q[i]) begin
      n_checks++;
      if ({dvalid, dout, busy, done} !== exp_q[i]) begin
        n_fail++; $display("FAIL %s cyc%0d: got %b exp %b", name, i, {dvalid, dout, busy, done}, exp_q[i]);
      end
      step();
    end
  endtask

  task automatic test_ignored();
    repeat_n = '0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({dvalid, dout, busy, done} !== 4'b0000) begin
        n_fail++; $display("FAIL ignore_zero cyc%0d: got %b exp 0000", i, {dvalid, dout, busy, done});
      end
    end
    repeat_n = 8'd2;
    step();
    build_model(2, -1);
    foreach (exp_q[i]) begin
      n_checks++;
      if ({dvalid, dout, busy, done} !== exp_q[i]) begin
        n_fail++; $display("FAIL ignore_busy cyc%0d: got %b exp %b", i, {dvalid, dout, busy, done}, exp_q[i]);
      end
      // keep requesting while busy (incl. DONE) with varying counts
      start    = exp_q[i][1];
      repeat_n = CNT_W'($urandom_range(1, 9));
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    repeat_n = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    build_model(2, 2);
    foreach (exp_q[i]) begin
      n_checks++;
      if ({dvalid, dout, busy, done} !== exp_q[i]) begin
        n_fail++; $display("FAIL abort cyc%0d: got %b exp %b", i, {dvalid, dout, busy, done}, exp_q[i]);
      end
      abort = (i == 1);
      step();
    end
    abort = 1'b0;
    test_frames(1, "abort_restart");
  endtask

  task automatic test_async_reset();
    repeat_n = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    build_model(1, -1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({dvalid, dout, busy, done} !== exp_q[i]) begin
        n_fail++; $display("FAIL arst_pre cyc%0d: got %b exp %b", i, {dvalid, dout, busy, done}, exp_q[i]);
      end
      if (i < 2) step();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({dvalid, dout, busy, done} !== 4'b0000) begin
      n_fail++; $display("FAIL arst_immediate: got %b exp 0000", {dvalid, dout, busy, done});
    end
    step();
    #3 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({dvalid, dout, busy, done} !== 4'b0000) begin
        n_fail++; $display("FAIL arst_idle cyc%0d: got %b exp 0000", i, {dvalid, dout, busy, done});
      end
    end
    test_frames(1, "arst_restart");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n        = $urandom_range(1, 5);
      int abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, stream_len(n) - 1) : -1;
      int idle     = $urandom_range(0, 3);
      for (int w = 0; w < idle; w++) step();
      repeat_n = CNT_W'(n); start = 1'b1;
      abort    = $urandom_range(0, 1) == 1;   // start beats abort in IDLE
      step();
      start = 1'b0; abort = 1'b0;
      build_model(n, abort_at);
      foreach (exp_q[i]) begin
        n_checks++;
        if ({dvalid, dout, busy, done} !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random it%0d n=%0d ab=%0d cyc%0d: got %b exp %b",
                   it, n, abort_at, i, {dvalid, dout, busy, done}, exp_q[i]);
        end
        abort    = (i == abort_at - 1);
        start    = exp_q[i][1] && ($urandom_range(0, 1) == 1);
        repeat_n = CNT_W'($urandom_range(1, 7));
        step();
      end
      abort = 1'b0; start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_frames(1, "single");
    test_frames(3, "three");
    test_ignored();
    test_abort();
    test_async_reset();
    test_random();
    test_frames(255, "max_count");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
